// File: rtl/izh_neuron_scheduler_if.sv
// Bundle between the network/stimulus side, the scheduler and the shared RK4 solver.
// The scheduler takes the slave view; the surrounding logic takes the master view.
interface izh_neuron_scheduler_if #(
    parameter int IDX_W = 3
);
    logic             tick_en;
    logic             i_wr_en;
    logic [IDX_W-1:0] i_wr_idx;
    logic [15:0]      i_wr_data;
    logic             sol_start;
    logic [15:0]      sol_v;
    logic [15:0]      sol_u;
    logic [15:0]      sol_i;
    logic [15:0]      sol_v_next;
    logic [15:0]      sol_u_next;
    logic             sol_spike;
    logic             sol_done;
    logic             spk_valid;
    logic [IDX_W-1:0] spk_idx;
    logic             busy;
    logic             step_done;
    logic [15:0]      step_count;
    logic             overrun;
    logic             timeout_err;

    modport slave (
        input  tick_en, i_wr_en, i_wr_idx, i_wr_data,
        input  sol_v_next, sol_u_next, sol_spike, sol_done,
        output sol_start, sol_v, sol_u, sol_i,
        output spk_valid, spk_idx, busy, step_done, step_count, overrun, timeout_err
    );

    modport master (
        output tick_en, i_wr_en, i_wr_idx, i_wr_data,
        output sol_v_next, sol_u_next, sol_spike, sol_done,
        input  sol_start, sol_v, sol_u, sol_i,
        input  spk_valid, spk_idx, busy, step_done, step_count, overrun, timeout_err
    );
endinterface

// File: rtl/izh_neuron_scheduler.sv
// Time-multiplexes one external RK4 Izhikevich solver over N_NEURONS neurons,
// holding per-neuron v/u/I state (signed 9.7) and applying the spike reset on write-back.
module izh_neuron_scheduler #(
    parameter int          N_NEURONS = 8,
    parameter int          IDX_W     = 3,
    parameter logic [15:0] C_PARAM   = 16'hDF80,
    parameter logic [15:0] D_PARAM   = 16'h0300,
    parameter logic [15:0] V_INIT    = 16'hDF80,
    parameter int          TIMEOUT   = 255
) (
    input logic                   clk,
    input logic                   rst,
    izh_neuron_scheduler_if.slave bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [CNT_W-1:0] r_wcnt;
    logic [15:0]      r_v [N_NEURONS];
    logic [15:0]      r_u [N_NEURONS];
    logic [15:0]      r_i [N_NEURONS];
    logic [15:0]      r_sol_v, r_sol_u, r_sol_i;
    logic [15:0]      r_v_res, r_u_res;
    logic             r_spike, r_wb_en;
    logic             r_sol_start, r_spk_valid, r_busy, r_step_done;
    logic [IDX_W-1:0] r_spk_idx;
    logic [15:0]      r_step_count;
    logic             r_overrun, r_timeout_err;
    logic             w_wait_done, w_wait_to;

    // Signed 16-bit add that clamps instead of wrapping.
    function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15]) begin
            sat16 = s[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            sat16 = s[15:0];
        end
    endfunction

    // Next state and next neuron index.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wait_done = 1'b0;
        w_wait_to   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_idx_nxt = '0;
                if (bus.tick_en) begin
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.sol_done) begin
                    w_wait_done = 1'b1;
                    w_state_nxt = S_WB;
                end else if (r_wcnt == TO_LAST) begin
                    w_wait_to   = 1'b1;
                    w_state_nxt = S_WB;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WB: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_state_nxt = S_ISSUE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, neuron memories and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_wcnt        <= '0;
            for (int k = 0; k < N_NEURONS; k++) begin
                r_v[k] <= V_INIT;
                r_u[k] <= 16'h0000;
                r_i[k] <= 16'h0000;
            end
            r_sol_v       <= V_INIT;
            r_sol_u       <= 16'h0000;
            r_sol_i       <= 16'h0000;
            r_v_res       <= 16'h0000;
            r_u_res       <= 16'h0000;
            r_spike       <= 1'b0;
            r_wb_en       <= 1'b0;
            r_sol_start   <= 1'b0;
            r_spk_valid   <= 1'b0;
            r_spk_idx     <= '0;
            r_busy        <= 1'b0;
            r_step_done   <= 1'b0;
            r_step_count  <= 16'h0000;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_sol_start <= (w_state_nxt == S_ISSUE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_step_done <= (w_state_nxt == S_DONE);
            r_spk_valid <= w_wait_done & bus.sol_spike;
            if (bus.i_wr_en) begin
                r_i[bus.i_wr_idx] <= bus.i_wr_data;
            end
            if (bus.tick_en && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            // Operands are presented together with the start pulse, so load them on entry to ISSUE.
            if (w_state_nxt == S_ISSUE) begin
                r_sol_v <= r_v[w_idx_nxt];
                r_sol_u <= r_u[w_idx_nxt];
                r_sol_i <= r_i[w_idx_nxt];
                r_wcnt  <= '0;
            end else if (r_state == S_WAIT) begin
                r_wcnt <= r_wcnt + CNT_W'(1);
            end
            if (w_wait_done) begin
                r_wb_en   <= 1'b1;
                r_spike   <= bus.sol_spike;
                r_v_res   <= bus.sol_v_next;
                r_u_res   <= bus.sol_u_next;
                r_spk_idx <= r_idx;
            end else if (w_wait_to) begin
                r_wb_en       <= 1'b0;
                r_spike       <= 1'b0;
                r_timeout_err <= 1'b1;
            end
            if ((r_state == S_WB) && r_wb_en) begin
                if (r_spike) begin
                    r_v[r_idx] <= C_PARAM;
                    r_u[r_idx] <= sat16(r_u_res, D_PARAM);
                end else begin
                    r_v[r_idx] <= r_v_res;
                    r_u[r_idx] <= r_u_res;
                end
            end
            if (r_state == S_DONE) begin
                r_step_count <= r_step_count + 16'h0001;
            end
        end
    end

    assign bus.sol_start   = r_sol_start;
    assign bus.sol_v       = r_sol_v;
    assign bus.sol_u       = r_sol_u;
    assign bus.sol_i       = r_sol_i;
    assign bus.spk_valid   = r_spk_valid;
    assign bus.spk_idx     = r_spk_idx;
    assign bus.busy        = r_busy;
    assign bus.step_done   = r_step_done;
    assign bus.step_count  = r_step_count;
    assign bus.overrun     = r_overrun;
    assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// Directed bench: solver responder, reference neuron model and issue/spike scoreboards.
module tb_izh_neuron_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    izh_neuron_scheduler_if #(.IDX_W(3)) b();
    izh_neuron_scheduler dut (.clk(clk), .rst(rst), .bus(b));

    typedef struct {
        int          idx;
        logic [15:0] v;
        logic [15:0] u;
        logic [15:0] i;
    } iss_t;

    iss_t        exp_q[$];
    int          spk_q[$];
    logic [15:0] m_v[8];
    logic [15:0] m_u[8];
    logic [15:0] m_i[8];
    int          checks = 0;
    int          errors = 0;
    int          sol_cnt = 0;
    int          lat_l = 4;
    int          cur_idx = 0;
    logic [15:0] cur_v, cur_u, cur_i;
    int          force_idx = -1;
    logic [15:0] force_u = 16'h0000;
    int          hang_idx = -1;
    int          starts = 0;
    int          spikes = 0;
    int          exp_sc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_sat(input logic [15:0] a);
        int s;
        s = int'($signed(a)) + 768;
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_v[k] = 16'hDF80;
            m_u[k] = 16'h0000;
            m_i[k] = 16'h0000;
        end
    endtask

    // Solver result: arbitrary but deterministic function of the issued operands.
    task automatic respond();
        logic [15:0] vn, un;
        logic        sp;
        vn = cur_v + 16'h0040 + {{2{cur_i[15]}}, cur_i[15:2]};
        un = cur_u + 16'h0010;
        sp = (cur_idx == force_idx);
        if (sp) un = force_u;
        b.sol_v_next = vn;
        b.sol_u_next = un;
        b.sol_spike  = sp;
        b.sol_done   = 1'b1;
        if (sp) begin
            m_v[cur_idx] = 16'hDF80;
            m_u[cur_idx] = ref_sat(un);
            spk_q.push_back(cur_idx);
        end else begin
            m_v[cur_idx] = vn;
            m_u[cur_idx] = un;
        end
    endtask

    task automatic tick();
        iss_t e;
        int   si;
        @(negedge clk);
        b.sol_done  = 1'b0;
        b.sol_spike = 1'b0;
        if (sol_cnt > 0) begin
            sol_cnt--;
            if (sol_cnt == 0) respond();
        end
        if (b.sol_start) begin
            starts++;
            if (exp_q.size() == 0) begin
                chk("unexpected_start", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("sol_v[%0d]", e.idx), {16'h0, b.sol_v}, {16'h0, e.v});
                chk($sformatf("sol_u[%0d]", e.idx), {16'h0, b.sol_u}, {16'h0, e.u});
                chk($sformatf("sol_i[%0d]", e.idx), {16'h0, b.sol_i}, {16'h0, e.i});
                cur_idx = e.idx;
                cur_v   = e.v;
                cur_u   = e.u;
                cur_i   = e.i;
                if (e.idx != hang_idx) sol_cnt = lat_l + 1;
            end
        end
        if (b.spk_valid) begin
            spikes++;
            if (spk_q.size() == 0) begin
                chk("unexpected_spike", 32'd1, 32'd0);
            end else begin
                si = spk_q.pop_front();
                chk("spk_idx", {29'h0, b.spk_idx}, 32'(si));
            end
        end
    endtask

    task automatic push_sweep();
        iss_t e;
        for (int k = 0; k < 8; k++) begin
            e.idx = k; e.v = m_v[k]; e.u = m_u[k]; e.i = m_i[k];
            exp_q.push_back(e);
        end
    endtask

    // Runs one sweep; lat counts cycles from the tick_en cycle to step_done.
    task automatic sweep(input bit hold, output int lat);
        bit found;
        push_sweep();
        b.tick_en = 1'b1;
        found = 1'b0;
        lat = 0;
        for (int k = 0; k < 2000 && !found; k++) begin
            tick();
            lat++;
            if (!hold) b.tick_en = 1'b0;
            if (b.step_done) found = 1'b1;
        end
        b.tick_en = 1'b0;
        if (!found) chk("step_done_timeout", 32'd0, 32'd1);
        exp_sc++;
        tick();
        chk("busy_after_sweep", {31'h0, b.busy}, 32'd0);
        chk("step_count", {16'h0, b.step_count}, 32'(exp_sc));
        chk("issue_queue_left", 32'(exp_q.size()), 32'd0);
        chk("spike_queue_left", 32'(spk_q.size()), 32'd0);
    endtask

    task automatic write_i(input int idx, input logic [15:0] d);
        b.i_wr_en   = 1'b1;
        b.i_wr_idx  = 3'(idx);
        b.i_wr_data = d;
        m_i[idx]    = d;
        tick();
        b.i_wr_en   = 1'b0;
    endtask

    initial begin
        int lat, s0, k0;
        b.tick_en = 1'b0; b.i_wr_en = 1'b0; b.i_wr_idx = 3'd0; b.i_wr_data = 16'h0000;
        b.sol_v_next = 16'h0000; b.sol_u_next = 16'h0000; b.sol_spike = 1'b0; b.sol_done = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_sol_v", {16'h0, b.sol_v}, 32'h0000DF80);
        chk("rst_sol_u", {16'h0, b.sol_u}, 32'd0);
        chk("rst_sol_i", {16'h0, b.sol_i}, 32'd0);
        chk("rst_busy", {31'h0, b.busy}, 32'd0);
        chk("rst_sol_start", {31'h0, b.sol_start}, 32'd0);
        chk("rst_step_count", {16'h0, b.step_count}, 32'd0);
        chk("rst_flags", {29'h0, b.overrun, b.timeout_err, b.spk_valid}, 32'd0);
        rst = 1'b0;
        tick();

        // T1: plain sweep, L=4
        s0 = starts;
        sweep(1'b0, lat);
        chk("t1_latency", 32'(lat), 32'd57);
        chk("t1_starts", 32'(starts - s0), 32'd8);
        chk("t1_overrun", {31'h0, b.overrun}, 32'd0);

        // T2: distinct currents, forced spike on neuron 3
        for (int k = 0; k < 8; k++) write_i(k, 16'(k * 16'h0080));
        write_i(3, 16'h0500);
        force_idx = 3; force_u = 16'h0100;
        s0 = spikes;
        sweep(1'b0, lat);
        chk("t2_spikes", 32'(spikes - s0), 32'd1);
        chk("t2_model_u3", {16'h0, m_u[3]}, 32'h00000400);

        // T3: spike with u near positive limit on neuron 5
        force_idx = 5; force_u = 16'h7E00;
        sweep(1'b0, lat);
        force_idx = -1;

        // T4: tick_en held through the whole sweep
        s0 = starts;
        sweep(1'b1, lat);
        repeat (3) tick();
        chk("t4_starts", 32'(starts - s0), 32'd8);
        chk("t4_overrun", {31'h0, b.overrun}, 32'd1);
        chk("t4_idle", {31'h0, b.busy}, 32'd0);
        sweep(1'b0, lat);
        chk("t4_second_latency", 32'(lat), 32'd57);

        // T5: solver never answers neuron 2
        hang_idx = 2;
        sweep(1'b0, lat);
        chk("t5_timeout", {31'h0, b.timeout_err}, 32'd1);
        chk("t5_latency", 32'(lat), 32'(7 * 7 + 257 + 1));
        hang_idx = -1;
        sweep(1'b0, lat);

        // T6: reset while waiting on neuron 5
        push_sweep();
        s0 = starts;
        b.tick_en = 1'b1;
        tick();
        b.tick_en = 1'b0;
        k0 = 0;
        while ((starts - s0) < 6 && k0 < 200) begin
            tick();
            k0++;
        end
        chk("t6_reached_idx5", 32'(starts - s0), 32'd6);
        tick();
        tick();
        rst = 1'b1;
        sol_cnt = 0;
        exp_q.delete();
        spk_q.delete();
        tick();
        chk("t6_busy", {31'h0, b.busy}, 32'd0);
        chk("t6_sol_v", {16'h0, b.sol_v}, 32'h0000DF80);
        chk("t6_sol_u", {16'h0, b.sol_u}, 32'd0);
        chk("t6_step_count", {16'h0, b.step_count}, 32'd0);
        chk("t6_flags", {30'h0, b.overrun, b.timeout_err}, 32'd0);
        rst = 1'b0;
        model_reset();
        exp_sc = 0;
        tick();
        sweep(1'b0, lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
